// File: rtl/rect_fill_engine_pkg.sv
// rect_fill_engine_pkg: shared frame-buffer defaults, field widths and FSM encoding
package rect_fill_engine_pkg;
  localparam int FB_W_DEF = 160;
  localparam int FB_H_DEF = 120;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FILL = 2'd1, S_DONE = 2'd2} state_t;
endpackage

// File: rtl/rect_fill_engine_if.sv
// rect_fill_engine_if: command inputs, status and frame-buffer write port of the fill engine
interface rect_fill_engine_if;
  import rect_fill_engine_pkg::*;
  logic          start;
  logic          outline;
  logic [XW-1:0] x0;
  logic [XW-1:0] x1;
  logic [YW-1:0] y0;
  logic [YW-1:0] y1;
  logic [CW-1:0] color;
  logic          busy;
  logic          done;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [CW-1:0] din;
  logic          wren;
  modport master(output start, outline, x0, x1, y0, y1, color,
                 input busy, done, x, y, din, wren);
  modport slave(input start, outline, x0, x1, y0, y1, color,
                output busy, done, x, y, din, wren);
endinterface

// File: rtl/rect_fill_engine_rect_norm.sv
// rect_norm: sorts rectangle corners, clips the far edges to the frame buffer and flags empty commands
module rect_norm
  import rect_fill_engine_pkg::*;
#(
  parameter int FB_W = FB_W_DEF,
  parameter int FB_H = FB_H_DEF
) (
  input  logic [XW-1:0] i_x0,
  input  logic [XW-1:0] i_x1,
  input  logic [YW-1:0] i_y0,
  input  logic [YW-1:0] i_y1,
  output logic [XW-1:0] o_xlo,
  output logic [XW-1:0] o_xhi,
  output logic [YW-1:0] o_ylo,
  output logic [YW-1:0] o_yhi,
  output logic          o_empty
);
  localparam logic [XW-1:0] XMAX = XW'(FB_W - 1);
  localparam logic [YW-1:0] YMAX = YW'(FB_H - 1);
  logic [XW-1:0] w_xhi;
  logic [YW-1:0] w_yhi;
  always_comb begin
    o_xlo   = i_x0 < i_x1 ? i_x0 : i_x1;
    w_xhi   = i_x0 < i_x1 ? i_x1 : i_x0;
    o_ylo   = i_y0 < i_y1 ? i_y0 : i_y1;
    w_yhi   = i_y0 < i_y1 ? i_y1 : i_y0;
    o_xhi   = w_xhi > XMAX ? XMAX : w_xhi;
    o_yhi   = w_yhi > YMAX ? YMAX : w_yhi;
    o_empty = o_xlo > XMAX || o_ylo > YMAX;
  end
endmodule

// File: rtl/rect_fill_engine.sv
// rect_fill_engine: rasterises a solid or outlined rectangle into a frame-buffer RAM, one pixel per cycle
module rect_fill_engine
  import rect_fill_engine_pkg::*;
#(
  parameter int FB_W = FB_W_DEF,
  parameter int FB_H = FB_H_DEF
) (
  input logic            clk,
  input logic            resetn,
  rect_fill_engine_if.slave bus
);
  state_t        r_state, w_next;
  logic [XW-1:0] w_xlo, w_xhi, r_xlo, r_xhi, r_cx;
  logic [YW-1:0] w_ylo, w_yhi, r_ylo, r_yhi, r_cy;
  logic [CW-1:0] r_color;
  logic          r_outline, w_empty, w_accept, w_last, w_border;
  rect_norm #(.FB_W(FB_W), .FB_H(FB_H)) u_norm (
    .i_x0(bus.x0), .i_x1(bus.x1), .i_y0(bus.y0), .i_y1(bus.y1),
    .o_xlo(w_xlo), .o_xhi(w_xhi), .o_ylo(w_ylo), .o_yhi(w_yhi), .o_empty(w_empty)
  );
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  always_comb begin
    w_accept = r_state == S_IDLE && bus.start;
    w_last   = r_cx == r_xhi && r_cy == r_yhi;
    w_border = r_cx == r_xlo || r_cx == r_xhi || r_cy == r_ylo || r_cy == r_yhi;
    w_next   = r_state == S_IDLE ? (bus.start ? (w_empty ? S_DONE : S_FILL) : S_IDLE)
             : r_state == S_FILL ? (w_last ? S_DONE : S_FILL)
             : S_IDLE;
  end
  // The pixel counters double as the x/y outputs: loaded with the first pixel
  // on acceptance, parked on the last pixel afterwards so the RAM port holds.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_xlo     <= '0;
      r_xhi     <= '0;
      r_ylo     <= '0;
      r_yhi     <= '0;
      r_cx      <= '0;
      r_cy      <= '0;
      r_color   <= '0;
      r_outline <= 1'b0;
    end else if (w_accept && !w_empty) begin
      r_xlo     <= w_xlo;
      r_xhi     <= w_xhi;
      r_ylo     <= w_ylo;
      r_yhi     <= w_yhi;
      r_cx      <= w_xlo;
      r_cy      <= w_ylo;
      r_color   <= bus.color;
      r_outline <= bus.outline;
    end else if (r_state == S_FILL && !w_last) begin
      r_cx <= r_cx == r_xhi ? r_xlo : r_cx + 1'b1;
      r_cy <= r_cx == r_xhi ? r_cy + 1'b1 : r_cy;
    end
  assign bus.busy = r_state == S_FILL;
  assign bus.done = r_state == S_DONE;
  assign bus.wren = r_state == S_FILL && (!r_outline || w_border);
  assign bus.x    = r_cx;
  assign bus.y    = r_cy;
  assign bus.din  = r_color;
endmodule

// File: tb/tb_rect_fill_engine.sv
// tb_rect_fill_engine: scenario tasks checked against a pixel-list reference model of the rectangle
module tb_rect_fill_engine;
  import rect_fill_engine_pkg::*;
  localparam int W = 160;
  localparam int H = 120;
  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic       w;
    logic [2:0] d;
  } px_t;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;
  rect_fill_engine_if bus ();
  rect_fill_engine dut (.clk(clk), .resetn(resetn), .bus(bus));
  px_t exp_q[$];
  px_t obs_q[$];
  int  checks = 0;
  int  failures = 0;
  bit  done_seen;
  int  done_at;
  int  stray;

  // Expected per-cycle pixel list: every cell of the clipped rectangle in raster order.
  task automatic model(int x0, int x1, int y0, int y1, bit ol, logic [2:0] c);
    int xl, xh, yl, yh;
    exp_q.delete();
    xl = x0 < x1 ? x0 : x1;
    xh = x0 < x1 ? x1 : x0;
    yl = y0 < y1 ? y0 : y1;
    yh = y0 < y1 ? y1 : y0;
    if (xh > W - 1) xh = W - 1;
    if (yh > H - 1) yh = H - 1;
    if (xl > W - 1 || yl > H - 1) return;
    for (int yy = yl; yy <= yh; yy++)
      for (int xx = xl; xx <= xh; xx++)
        exp_q.push_back({8'(xx), 7'(yy), !ol || xx == xl || xx == xh || yy == yl || yy == yh, c});
  endtask

  task automatic issue(int x0, int x1, int y0, int y1, bit ol, logic [2:0] c);
    model(x0, x1, y0, y1, ol, c);
    bus.x0 = 8'(x0);
    bus.x1 = 8'(x1);
    bus.y0 = 7'(y0);
    bus.y1 = 7'(y1);
    bus.outline = ol;
    bus.color = c;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Records the write port every busy cycle until done; optionally pulses a foreign start.
  task automatic collect(int limit, int poke_at);
    obs_q.delete();
    done_seen = 0;
    done_at = -1;
    stray = 0;
    for (int i = 0; i < limit; i++) begin
      if (bus.done) begin
        done_seen = 1;
        done_at = i;
        bus.start = 1'b0;
        if (bus.busy || bus.wren) stray++;
        break;
      end
      if (bus.busy) obs_q.push_back({bus.x, bus.y, bus.wren, bus.din});
      else if (bus.wren) stray++;
      if (i == poke_at) begin
        bus.x0 = 8'd0; bus.x1 = 8'd5; bus.y0 = 7'd0; bus.y1 = 7'd5;
        bus.color = 3'd1; bus.outline = 1'b1; bus.start = 1'b1;
      end else bus.start = 1'b0;
      @(negedge clk);
    end
  endtask

  function automatic int ndiff();
    int n = obs_q.size() == exp_q.size() ? 0 : 1;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) n++;
    return n;
  endfunction

  task automatic test_reset();
    bus.start = 0; bus.outline = 0; bus.x0 = 0; bus.x1 = 0; bus.y0 = 0; bus.y1 = 0; bus.color = 0;
    resetn = 1'b0;
    #2;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", bus.done); end
    checks++; if (bus.wren !== 1'b0) begin failures++; $display("FAIL reset_wren got=%b want=0", bus.wren); end
    checks++; if ({bus.x, bus.y, bus.din} !== 18'd0) begin failures++; $display("FAIL reset_xydin got=%0d,%0d,%0d want=0,0,0", bus.x, bus.y, bus.din); end
  endtask

  task automatic test_fill();
    @(negedge clk);
    resetn = 1'b1;
    issue(10, 12, 5, 6, 0, 3'b101);
    collect(40, -1);
    checks++; if (obs_q.size() != 6) begin failures++; $display("FAIL fill_len got=%0d want=6", obs_q.size()); end
    checks++; if (ndiff() != 0) begin failures++; $display("FAIL fill_seq diffs=%0d want=0", ndiff()); end
    checks++; if ({obs_q[0].x, obs_q[0].y, obs_q[0].d} !== {8'd10, 7'd5, 3'd5}) begin failures++; $display("FAIL fill_first got=%0d,%0d,%0d want=10,5,5", obs_q[0].x, obs_q[0].y, obs_q[0].d); end
    checks++; if (done_at != 6 || stray != 0) begin failures++; $display("FAIL fill_done done_at=%0d stray=%0d want=6,0", done_at, stray); end
    @(negedge clk);
    checks++; if ({bus.done, bus.busy, bus.wren} !== 3'b000) begin failures++; $display("FAIL fill_after got=%b want=000", {bus.done, bus.busy, bus.wren}); end
    checks++; if ({bus.x, bus.y, bus.din} !== {8'd12, 7'd6, 3'd5}) begin failures++; $display("FAIL fill_hold got=%0d,%0d,%0d want=12,6,5", bus.x, bus.y, bus.din); end
  endtask

  task automatic test_swap_clip();
    @(negedge clk);
    issue(159, 150, 119, 118, 0, 3'd2);
    collect(60, -1);
    checks++; if (obs_q.size() != 20 || ndiff() != 0) begin failures++; $display("FAIL swap_seq len=%0d diffs=%0d want=20,0", obs_q.size(), ndiff()); end
    checks++; if ({obs_q[0].x, obs_q[0].y} !== {8'd150, 7'd118}) begin failures++; $display("FAIL swap_first got=%0d,%0d want=150,118", obs_q[0].x, obs_q[0].y); end
    @(negedge clk);
    issue(155, 200, 10, 11, 0, 3'd6);
    collect(60, -1);
    checks++; if (obs_q.size() != 10 || ndiff() != 0) begin failures++; $display("FAIL clip_seq len=%0d diffs=%0d want=10,0", obs_q.size(), ndiff()); end
    checks++; if (obs_q[4].x !== 8'd159 || !done_seen) begin failures++; $display("FAIL clip_edge got=%0d done=%0d want=159,1", obs_q[4].x, done_seen); end
  endtask

  task automatic test_outline();
    int nw;
    @(negedge clk);
    issue(0, 3, 0, 3, 1, 3'd7);
    collect(60, -1);
    nw = 0;
    foreach (obs_q[i]) nw += int'(obs_q[i].w);
    checks++; if (obs_q.size() != 16 || ndiff() != 0) begin failures++; $display("FAIL outline_seq len=%0d diffs=%0d want=16,0", obs_q.size(), ndiff()); end
    checks++; if (nw != 12) begin failures++; $display("FAIL outline_count got=%0d want=12", nw); end
    checks++; if ({obs_q[5].w, obs_q[6].w, obs_q[9].w, obs_q[10].w} !== 4'b0000) begin failures++; $display("FAIL outline_inner got=%b want=0000", {obs_q[5].w, obs_q[6].w, obs_q[9].w, obs_q[10].w}); end
  endtask

  task automatic test_empty_degenerate();
    @(negedge clk);
    issue(170, 170, 3, 4, 0, 3'd1);
    collect(10, -1);
    checks++; if (done_at != 0 || obs_q.size() != 0 || stray != 0) begin failures++; $display("FAIL empty_x done_at=%0d writes=%0d stray=%0d want=0,0,0", done_at, obs_q.size(), stray); end
    @(negedge clk);
    issue(5, 6, 120, 127, 0, 3'd1);
    collect(10, -1);
    checks++; if (done_at != 0 || obs_q.size() != 0) begin failures++; $display("FAIL empty_y done_at=%0d writes=%0d want=0,0", done_at, obs_q.size()); end
    @(negedge clk);
    issue(7, 7, 7, 7, 0, 3'd4);
    collect(10, -1);
    checks++; if (done_at != 1 || ndiff() != 0) begin failures++; $display("FAIL single done_at=%0d diffs=%0d want=1,0", done_at, ndiff()); end
  endtask

  task automatic test_ignore_start();
    @(negedge clk);
    issue(20, 29, 30, 33, 0, 3'd3);
    collect(80, 15);
    checks++; if (obs_q.size() != 40 || ndiff() != 0 || done_at != 40) begin failures++; $display("FAIL ignore_busy len=%0d diffs=%0d done_at=%0d want=40,0,40", obs_q.size(), ndiff(), done_at); end
    bus.x0 = 8'd0; bus.x1 = 8'd5; bus.y0 = 7'd0; bus.y1 = 7'd5; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checks++; if ({bus.busy, bus.done, bus.x, bus.y, bus.din} !== {2'b00, 8'd29, 7'd33, 3'd3}) begin failures++; $display("FAIL ignore_done busy=%b done=%b xy=%0d,%0d din=%0d want=0,0,29,33,3", bus.busy, bus.done, bus.x, bus.y, bus.din); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL ignore_done_late busy=%b want=0", bus.busy); end
  endtask

  task automatic test_reset_abort();
    int bad;
    @(negedge clk);
    issue(40, 60, 40, 50, 0, 3'd5);
    collect(10, -1);
    #3 resetn = 1'b0;
    #1;
    checks++; if ({bus.wren, bus.busy, bus.done} !== 3'b000 || {bus.x, bus.y, bus.din} !== 18'd0) begin failures++; $display("FAIL abort_now wbd=%b xy=%0d,%0d din=%0d want=000,0,0,0", {bus.wren, bus.busy, bus.done}, bus.x, bus.y, bus.din); end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.done || bus.wren) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL abort_quiet got=%0d want=0", bad); end
    resetn = 1'b1;
    issue(3, 1, 2, 4, 1, 3'd6);
    collect(40, -1);
    checks++; if (ndiff() != 0 || done_at != 9) begin failures++; $display("FAIL abort_resume diffs=%0d done_at=%0d want=0,9", ndiff(), done_at); end
  endtask

  task automatic test_full_screen();
    @(negedge clk);
    issue(0, 159, 0, 119, 0, 3'd2);
    collect(20000, -1);
    checks++; if (obs_q.size() != 19200 || done_at != 19200) begin failures++; $display("FAIL full_len got=%0d done_at=%0d want=19200", obs_q.size(), done_at); end
    checks++; if (ndiff() != 0) begin failures++; $display("FAIL full_seq diffs=%0d want=0", ndiff()); end
    checks++; if ({obs_q[19199].x, obs_q[19199].y} !== {8'd159, 7'd119}) begin failures++; $display("FAIL full_last got=%0d,%0d want=159,119", obs_q[19199].x, obs_q[19199].y); end
  endtask

  task automatic test_random();
    int xa, xb, ya, yb;
    for (int n = 0; n < 30; n++) begin
      xa = $urandom_range(0, 255);
      ya = $urandom_range(0, 127);
      xb = xa + $urandom_range(0, 12); if (xb > 255) xb = 255;
      yb = ya + $urandom_range(0, 6);  if (yb > 127) yb = 127;
      @(negedge clk);
      if ($urandom_range(0, 1) == 1) issue(xb, xa, yb, ya, 1'($urandom), 3'($urandom));
      else                           issue(xa, xb, ya, yb, 1'($urandom), 3'($urandom));
      collect(exp_q.size() + 20, -1);
      checks++; if (ndiff() != 0 || done_at != exp_q.size() || stray != 0) begin failures++; $display("FAIL random_%0d diffs=%0d done_at=%0d stray=%0d want=0,%0d,0", n, ndiff(), done_at, stray, exp_q.size()); end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_swap_clip();
    test_outline();
    test_empty_degenerate();
    test_ignore_start();
    test_reset_abort();
    test_full_screen();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
